// File: rtl/port_wr_frontend_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// port_wr_frontend_if : write stream, descriptor and replay signals of one port
// Revision 1.0
// ---------------------------------------------------------------------------
interface port_wr_frontend_if;
  logic        wr_sop;
  logic        wr_vld;
  logic [15:0] wr_data;
  logic        wr_eop;
  logic        wr_full;
  logic        pkt_vld;
  logic [3:0]  pkt_dest_port;
  logic [2:0]  pkt_prior;
  logic [8:0]  pkt_length;
  logic        pkt_ack;
  logic        out_ready;
  logic        out_data_vld;
  logic [15:0] out_data;
  logic        end_of_packet;
  logic        pkt_drop;

  modport slave (
    input  wr_sop, wr_vld, wr_data, wr_eop, pkt_ack,
    output wr_full, pkt_vld, pkt_dest_port, pkt_prior, pkt_length,
           out_ready, out_data_vld, out_data, end_of_packet, pkt_drop
  );

  modport master (
    output wr_sop, wr_vld, wr_data, wr_eop, pkt_ack,
    input  wr_full, pkt_vld, pkt_dest_port, pkt_prior, pkt_length,
           out_ready, out_data_vld, out_data, end_of_packet, pkt_drop
  );
endinterface
`default_nettype wire

// File: rtl/port_wr_frontend.sv
`default_nettype none
// ---------------------------------------------------------------------------
// port_wr_frontend : buffers one port's write packets, queues descriptors and
// replays bodies after ack. Optional macro PORT_WR_LEN_CHECK_EN. Revision 1.0
// ---------------------------------------------------------------------------
module port_wr_frontend #(
  parameter int DEPTH     = 256,
  parameter int HDR_DEPTH = 4,
  parameter int MAX_PKT   = 64
) (
  input wire clk,
  input wire rst,
  port_wr_frontend_if.slave bus
);

  localparam int AW  = $clog2(DEPTH);
  localparam int HAW = $clog2(HDR_DEPTH);
  localparam logic [AW:0]  PTR_ONE     = (AW+1)'(1);
  localparam logic [AW:0]  USED_LIM    = (AW+1)'(DEPTH - MAX_PKT);
  localparam logic [HAW:0] DQ_FULL_CNT = (HAW+1)'(HDR_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY, S_DISCARD} in_state_e;
  typedef enum logic [1:0] {O_IDLE, O_START, O_STREAM} out_state_e;

  in_state_e  in_state_q, in_state_d;
  out_state_e out_state_q, out_state_d;

`ifdef PORT_WR_LEN_CHECK_EN
  logic [15:0] hdr_q, hdr_d;
`else
  logic [6:0]  hdr_q, hdr_d;
`endif

  logic [9:0]   cnt_q, cnt_d;
  logic [AW:0]  wr_ptr_q, wr_ptr_d, wr_start_q, wr_start_d, rd_ptr_q, rd_ptr_d;
  logic [HAW:0] dq_wr_q, dq_wr_d, dq_rd_q, dq_rd_d;
  logic [8:0]   remain_q, remain_d;
  logic         drop_q, drop_d, full_q, full_d;
  logic         mem_we, push, pop, pkt_ok, dq_empty, dq_full;
  logic [15:0]  push_word, dq_raw;
  logic [AW:0]  used_d;
  logic [HAW:0] dq_cnt_d;

  logic [15:0] mem [DEPTH];
  logic [15:0] dq  [HDR_DEPTH];

  // Descriptor word layout: {length[8:0], prior[2:0], dest[3:0]}
`ifdef PORT_WR_LEN_CHECK_EN
  assign push_word = hdr_q;
`else
  assign push_word = {cnt_q[8:0], hdr_q};
`endif

  assign dq_raw   = dq[dq_rd_q[HAW-1:0]];
  assign dq_empty = (dq_wr_q == dq_rd_q);
  assign dq_full  = (dq_wr_q[HAW] != dq_rd_q[HAW]) &&
                    (dq_wr_q[HAW-1:0] == dq_rd_q[HAW-1:0]);

  always_comb begin
    in_state_d = in_state_q;
    cnt_d      = cnt_q;
    hdr_d      = hdr_q;
    wr_ptr_d   = wr_ptr_q;
    wr_start_d = wr_start_q;
    drop_d     = 1'b0;
    push       = 1'b0;
    mem_we     = 1'b0;
    pkt_ok     = (cnt_q != 10'd0) && (!dq_full || pop);
`ifdef PORT_WR_LEN_CHECK_EN
    pkt_ok     = pkt_ok && (cnt_q == {1'b0, hdr_q[15:7]});
`endif
    case (in_state_q)
      S_IDLE: begin
        if (bus.wr_sop) begin
          in_state_d = S_HEAD;
          cnt_d      = 10'd0;
        end
      end
      S_DISCARD: begin
        if (bus.wr_sop) begin
          in_state_d = S_HEAD;
          cnt_d      = 10'd0;
        end else if (bus.wr_eop) begin
          in_state_d = S_IDLE;
        end
      end
      default: begin
        if (bus.wr_sop) begin
          drop_d     = 1'b1;
          wr_ptr_d   = wr_start_q;
          cnt_d      = 10'd0;
          in_state_d = S_HEAD;
        end else if (bus.wr_eop) begin
          in_state_d = S_IDLE;
          if (pkt_ok) begin
            push       = 1'b1;
            wr_start_d = wr_ptr_q;
          end else begin
            drop_d   = 1'b1;
            wr_ptr_d = wr_start_q;
          end
        end else if (bus.wr_vld) begin
          if (in_state_q == S_HEAD) begin
            hdr_d      = bus.wr_data[$bits(hdr_q)-1:0];
            in_state_d = S_BODY;
          end else if (cnt_q == 10'(MAX_PKT)) begin
            // Oversized: discard everything up to the closing eop
            drop_d     = 1'b1;
            wr_ptr_d   = wr_start_q;
            in_state_d = S_DISCARD;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            cnt_d    = cnt_q + 10'd1;
          end
        end
      end
    endcase
  end

  always_comb begin
    out_state_d = out_state_q;
    rd_ptr_d    = rd_ptr_q;
    remain_d    = remain_q;
    pop         = 1'b0;
    case (out_state_q)
      O_IDLE: begin
        if (bus.pkt_ack && !dq_empty) begin
          pop         = 1'b1;
          remain_d    = dq_raw[15:7];
          out_state_d = O_START;
        end
      end
      O_START: out_state_d = O_STREAM;
      O_STREAM: begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        remain_d = remain_q - 9'd1;
        if (remain_q <= 9'd1) out_state_d = O_IDLE;
      end
      default: out_state_d = O_IDLE;
    endcase
  end

  // Backpressure looks at next-cycle committed occupancy so it is never stale
  assign dq_wr_d  = dq_wr_q + {{HAW{1'b0}}, push};
  assign dq_rd_d  = dq_rd_q + {{HAW{1'b0}}, pop};
  assign used_d   = wr_start_d - rd_ptr_d;
  assign dq_cnt_d = dq_wr_d - dq_rd_d;
  assign full_d   = (used_d > USED_LIM) || (dq_cnt_d == DQ_FULL_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      in_state_q  <= S_IDLE;
      out_state_q <= O_IDLE;
      hdr_q       <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      wr_start_q  <= '0;
      rd_ptr_q    <= '0;
      dq_wr_q     <= '0;
      dq_rd_q     <= '0;
      remain_q    <= '0;
      drop_q      <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
      hdr_q       <= hdr_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_start_q  <= wr_start_d;
      rd_ptr_q    <= rd_ptr_d;
      dq_wr_q     <= dq_wr_d;
      dq_rd_q     <= dq_rd_d;
      remain_q    <= remain_d;
      drop_q      <= drop_d;
      full_q      <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q[AW-1:0]] <= bus.wr_data;
    if (push)   dq[dq_wr_q[HAW-1:0]]  <= push_word;
  end

  assign bus.wr_full       = full_q;
  assign bus.pkt_drop      = drop_q;
  assign bus.pkt_vld       = !dq_empty;
  assign bus.pkt_length    = dq_empty ? 9'd0 : dq_raw[15:7];
  assign bus.pkt_prior     = dq_empty ? 3'd0 : dq_raw[6:4];
  assign bus.pkt_dest_port = dq_empty ? 4'd0 : dq_raw[3:0];
  assign bus.out_ready     = (out_state_q == O_START);
  assign bus.out_data_vld  = (out_state_q == O_STREAM);
  assign bus.out_data      = (out_state_q == O_STREAM) ? mem[rd_ptr_q[AW-1:0]] : 16'd0;
  assign bus.end_of_packet = (out_state_q == O_STREAM) && (remain_q == 9'd1);

endmodule
`default_nettype wire

// File: tb/tb_port_wr_frontend.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_port_wr_frontend : directed scenarios for the port write frontend
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_port_wr_frontend;

  logic clk = 1'b0;
  logic rst;
  int   n_run  = 0;
  int   n_fail = 0;
  int   drop_cnt = 0;
  int   eop_cnt  = 0;
  logic [16:0] cap_q[$];

  port_wr_frontend_if bus();

  port_wr_frontend dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Output recorder: {end_of_packet, out_data} of every valid body word
  always @(negedge clk) begin
    if (bus.out_data_vld === 1'b1) cap_q.push_back({bus.end_of_packet, bus.out_data});
    if (bus.pkt_drop === 1'b1) drop_cnt++;
    if (bus.end_of_packet === 1'b1) eop_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [15:0] hdr, input int n, input logic [15:0] base);
    bus.wr_sop = 1'b1; tick();
    bus.wr_sop = 1'b0; bus.wr_vld = 1'b1; bus.wr_data = hdr; tick();
    for (int i = 0; i < n; i++) begin
      bus.wr_data = 16'(base + 16'(i)); tick();
    end
    bus.wr_vld = 1'b0; bus.wr_eop = 1'b1; tick();
    bus.wr_eop = 1'b0;
  endtask

  function automatic logic [37:0] out_vec();
    return {bus.wr_full, bus.pkt_vld, bus.out_ready, bus.out_data_vld, bus.end_of_packet,
            bus.pkt_drop, bus.pkt_length, bus.pkt_dest_port, bus.pkt_prior, bus.out_data};
  endfunction

  task automatic test_reset();
    rst = 1'b1; repeat (3) tick();
    rst = 1'b0; tick();
    n_run++; if (out_vec() !== 38'd0) begin n_fail++; $display("FAIL reset_outputs got %h want 0", out_vec()); end
    bus.pkt_ack = 1'b1; tick(); bus.pkt_ack = 1'b0;
    n_run++; if (bus.out_ready !== 1'b0) begin n_fail++; $display("FAIL ack_when_empty out_ready got %b want 0", bus.out_ready); end
    tick();
    n_run++; if (bus.out_data_vld !== 1'b0) begin n_fail++; $display("FAIL ack_when_empty data_vld got %b want 0", bus.out_data_vld); end
  endtask

  task automatic test_basic();
    int b = cap_q.size();
    int d = drop_cnt;
    logic [16:0] e;
    bus.wr_vld = 1'b1; bus.wr_data = 16'hDEAD; tick(); bus.wr_vld = 1'b0;
    send_pkt(16'h0215, 4, 16'h00A1);
    n_run++; if ({bus.pkt_vld, bus.pkt_dest_port, bus.pkt_prior, bus.pkt_length} !== {1'b1, 4'd5, 3'd1, 9'd4}) begin
      n_fail++; $display("FAIL basic_desc got vld=%b dest=%0d prior=%0d len=%0d want 1/5/1/4",
                        bus.pkt_vld, bus.pkt_dest_port, bus.pkt_prior, bus.pkt_length); end
    bus.pkt_ack = 1'b1; tick(); bus.pkt_ack = 1'b0;
    n_run++; if ({bus.out_ready, bus.out_data_vld, bus.pkt_vld} !== 3'b100) begin
      n_fail++; $display("FAIL basic_ready got rdy/vld/pkt=%b want 100", {bus.out_ready, bus.out_data_vld, bus.pkt_vld}); end
    tick();
    n_run++; if ({bus.out_data_vld, bus.out_data} !== {1'b1, 16'h00A1}) begin
      n_fail++; $display("FAIL basic_first_word got %b/%h want 1/00a1", bus.out_data_vld, bus.out_data); end
    repeat (4) tick();
    n_run++; if (cap_q.size() - b !== 4) begin n_fail++; $display("FAIL basic_count got %0d want 4", cap_q.size() - b); end
    for (int i = 0; i < 4; i++) begin
      e = {(i == 3), 16'(16'h00A1 + 16'(i))};
      n_run++; if (cap_q[b+i] !== e) begin n_fail++; $display("FAIL basic_word%0d got %h want %h", i, cap_q[b+i], e); end
    end
    n_run++; if (drop_cnt !== d) begin n_fail++; $display("FAIL basic_nodrop got %0d want %0d", drop_cnt, d); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] hdrs  [3] = '{16'h0121, 16'h0182, 16'h00F3};
    int          lens  [3] = '{2, 3, 1};
    logic [2:0]  prios [3] = '{3'd2, 3'd0, 3'd7};
    logic [15:0] bases [3] = '{16'h00B0, 16'h00C0, 16'h00D0};
    logic [16:0] exp_q[$];
    int b = cap_q.size();
    for (int k = 0; k < 3; k++) send_pkt(hdrs[k], lens[k], bases[k]);
    repeat (5) tick();
    for (int k = 0; k < 3; k++) begin
      n_run++; if ({bus.pkt_vld, bus.pkt_dest_port, bus.pkt_prior, bus.pkt_length} !==
                   {1'b1, 4'(k + 1), prios[k], 9'(lens[k])}) begin
        n_fail++; $display("FAIL b2b_desc%0d got vld=%b dest=%0d prior=%0d len=%0d", k,
                          bus.pkt_vld, bus.pkt_dest_port, bus.pkt_prior, bus.pkt_length); end
      bus.pkt_ack = 1'b1; tick(); bus.pkt_ack = 1'b0;
      repeat (lens[k] + 1) tick();
      for (int j = 0; j < lens[k]; j++) exp_q.push_back({(j == lens[k] - 1), 16'(bases[k] + 16'(j))});
    end
    n_run++; if (bus.pkt_vld !== 1'b0) begin n_fail++; $display("FAIL b2b_empty got %b want 0", bus.pkt_vld); end
    n_run++; if (cap_q.size() - b !== 6) begin n_fail++; $display("FAIL b2b_count got %0d want 6", cap_q.size() - b); end
    for (int i = 0; i < 6; i++) begin
      n_run++; if (cap_q[b+i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_word%0d got %h want %h", i, cap_q[b+i], exp_q[i]); end
    end
  endtask

  task automatic test_overflow();
    int b = cap_q.size();
    int d = drop_cnt;
    send_pkt(16'h2086, 65, 16'h0100);
    tick();
    n_run++; if (drop_cnt !== d + 1) begin n_fail++; $display("FAIL ovf_drop got %0d want %0d", drop_cnt, d + 1); end
    n_run++; if ({bus.pkt_vld, bus.wr_full} !== 2'b00) begin n_fail++; $display("FAIL ovf_nodesc got vld/full=%b want 00", {bus.pkt_vld, bus.wr_full}); end
    send_pkt(16'h0239, 4, 16'h00E1);
    n_run++; if ({bus.pkt_vld, bus.pkt_dest_port, bus.pkt_prior, bus.pkt_length} !== {1'b1, 4'd9, 3'd3, 9'd4}) begin
      n_fail++; $display("FAIL ovf_next_desc got vld=%b dest=%0d prior=%0d len=%0d want 1/9/3/4",
                        bus.pkt_vld, bus.pkt_dest_port, bus.pkt_prior, bus.pkt_length); end
    bus.pkt_ack = 1'b1; tick(); bus.pkt_ack = 1'b0;
    repeat (5) tick();
    n_run++; if (cap_q.size() - b !== 4) begin n_fail++; $display("FAIL ovf_count got %0d want 4", cap_q.size() - b); end
    for (int i = 0; i < 4; i++) begin
      n_run++; if (cap_q[b+i] !== {(i == 3), 16'(16'h00E1 + 16'(i))}) begin
        n_fail++; $display("FAIL ovf_word%0d got %h want %h", i, cap_q[b+i], {(i == 3), 16'(16'h00E1 + 16'(i))}); end
    end
  endtask

  task automatic test_full();
    int b = cap_q.size();
    for (int k = 0; k < 3; k++) send_pkt(16'h0081, 1, 16'(16'h00F1 + 16'(k)));
    n_run++; if (bus.wr_full !== 1'b0) begin n_fail++; $display("FAIL full_at3 got %b want 0", bus.wr_full); end
    send_pkt(16'h0081, 1, 16'h00F4);
    tick();
    n_run++; if (bus.wr_full !== 1'b1) begin n_fail++; $display("FAIL full_at4 got %b want 1", bus.wr_full); end
    bus.pkt_ack = 1'b1; tick(); bus.pkt_ack = 1'b0;
    repeat (2) tick();
    repeat (2) tick();
    n_run++; if (bus.wr_full !== 1'b0) begin n_fail++; $display("FAIL full_release got %b want 0", bus.wr_full); end
    for (int k = 0; k < 3; k++) begin
      bus.pkt_ack = 1'b1; tick(); bus.pkt_ack = 1'b0;
      repeat (2) tick();
    end
    n_run++; if (cap_q.size() - b !== 4) begin n_fail++; $display("FAIL full_count got %0d want 4", cap_q.size() - b); end
    for (int i = 0; i < 4; i++) begin
      n_run++; if (cap_q[b+i] !== {1'b1, 16'(16'h00F1 + 16'(i))}) begin
        n_fail++; $display("FAIL full_word%0d got %h want %h", i, cap_q[b+i], {1'b1, 16'(16'h00F1 + 16'(i))}); end
    end
  endtask

  task automatic test_len_mismatch();
    int b = cap_q.size();
    int d = drop_cnt;
    send_pkt(16'h0215, 3, 16'h0071);
    tick();
`ifdef PORT_WR_LEN_CHECK_EN
    n_run++; if ({bus.pkt_vld, 4'(drop_cnt - d)} !== {1'b0, 4'd1}) begin
      n_fail++; $display("FAIL lenchk_drop got vld=%b drops=%0d want 0/1", bus.pkt_vld, drop_cnt - d); end
`else
    n_run++; if ({bus.pkt_vld, bus.pkt_length, 4'(drop_cnt - d)} !== {1'b1, 9'd3, 4'd0}) begin
      n_fail++; $display("FAIL lenfree_desc got vld=%b len=%0d drops=%0d want 1/3/0", bus.pkt_vld, bus.pkt_length, drop_cnt - d); end
    bus.pkt_ack = 1'b1; tick(); bus.pkt_ack = 1'b0;
    repeat (4) tick();
    n_run++; if (cap_q.size() - b !== 3 || cap_q[b+2] !== 17'h10073) begin
      n_fail++; $display("FAIL lenfree_data got n=%0d last=%h want 3/10073", cap_q.size() - b, cap_q[b+2]); end
`endif
  endtask

  task automatic test_reset_stream();
    int b = cap_q.size();
    int e = eop_cnt;
    send_pkt(16'h0215, 4, 16'h0051);
    send_pkt(16'h0081, 1, 16'h0061);
    bus.pkt_ack = 1'b1; tick(); bus.pkt_ack = 1'b0;
    tick(); tick();
    rst = 1'b1; tick();
    n_run++; if (out_vec() !== 38'd0) begin n_fail++; $display("FAIL rst_stream_outputs got %h want 0", out_vec()); end
    rst = 1'b0; repeat (3) tick();
    n_run++; if (bus.pkt_vld !== 1'b0) begin n_fail++; $display("FAIL rst_stream_queue got %b want 0", bus.pkt_vld); end
    n_run++; if (eop_cnt !== e) begin n_fail++; $display("FAIL rst_stream_eop got %0d want %0d", eop_cnt, e); end
    n_run++; if (cap_q.size() - b !== 2 || cap_q[b] !== 17'h00051 || cap_q[b+1] !== 17'h00052) begin
      n_fail++; $display("FAIL rst_stream_words got n=%0d w0=%h w1=%h want 2/00051/00052", cap_q.size() - b, cap_q[b], cap_q[b+1]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.wr_sop = 1'b0; bus.wr_vld = 1'b0; bus.wr_data = 16'd0; bus.wr_eop = 1'b0; bus.pkt_ack = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_full();
    test_len_mismatch();
    test_reset_stream();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
